// File: rtl/pc_pkg.sv
// pc_pkg: next-PC select encoding, default vectors and target alignment helper
package pc_pkg;
  typedef enum logic [2:0] {SEL_EXC, SEL_HOLD, SEL_RET, SEL_JR, SEL_JMP, SEL_BR, SEL_SEQ} sel_t;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_DEF = 32'h0000_0080;
  function automatic logic [63:0] align_mask(input int unsigned lsb);
    return ~((64'd1 << lsb) - 64'd1);
  endfunction
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack with saturating count and overflow/underflow pulses
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               top,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  output logic                       unf
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] ptr, ptr_m1;
  logic pop_ok, full;
  assign ptr_m1 = ptr - PW'(1);
  assign top = mem[ptr_m1];
  assign pop_ok = pop && count != '0;
  assign full = count == (PW+1)'(DEPTH);
  // push+pop on a non-empty stack replaces the top in place, leaving pointer and count alone
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      count <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= push && full && !pop_ok;
      unf <= pop && !pop_ok;
      if (push && pop_ok) mem[ptr_m1] <= wdata;
      else if (push) begin
        mem[ptr] <= wdata;
        ptr <= ptr + PW'(1);
        count <= full ? count : count + (PW+1)'(1);
      end else if (pop_ok) begin
        ptr <= ptr_m1;
        count <= count - (PW+1)'(1);
      end
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with branch/jump/return selection, stall, exception and RAS
module pc_sequencer import pc_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int INC = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
  parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(EXC_VEC_DEF),
  parameter int OFF_W = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         exc,
  input  logic                         br_taken,
  input  logic [OFF_W-1:0]             br_off,
  input  logic                         jump,
  input  logic [ADDR_W-1:0]            jump_tgt,
  input  logic                         jr,
  input  logic [ADDR_W-1:0]            jr_tgt,
  input  logic                         call,
  input  logic                         ret,
  output logic [ADDR_W-1:0]            pc,
  output logic [ADDR_W-1:0]            pc_inc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_ovf,
  output logic                         ras_unf
);
  localparam logic [ADDR_W-1:0] MASK = ADDR_W'(align_mask($clog2(INC)));
  sel_t sel;
  logic push, pop;
  logic [ADDR_W-1:0] top, br_tgt, raw, nxt;
  assign pc_inc = pc + ADDR_W'(INC);
  assign br_tgt = pc_inc + (ADDR_W'($signed(br_off)) << 2);
  always_comb begin
    sel = exc ? SEL_EXC : stall ? SEL_HOLD : ret ? SEL_RET : jr ? SEL_JR :
          jump ? SEL_JMP : br_taken ? SEL_BR : SEL_SEQ;
    pop = sel == SEL_RET;
    push = call && (pop || sel == SEL_JR || sel == SEL_JMP);
    raw = sel == SEL_EXC ? EXC_VEC :
          sel == SEL_RET ? (ras_count == '0 ? jr_tgt : top) :
          sel == SEL_JR  ? jr_tgt :
          sel == SEL_JMP ? jump_tgt :
          sel == SEL_BR  ? br_tgt : pc_inc;
    nxt = sel == SEL_HOLD ? pc : raw & MASK;
  end
  always_ff @(posedge clk) pc <= !rst_n ? RESET_VEC : nxt;
  ras_stack #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .wdata(pc_inc),
    .top(top),
    .count(ras_count),
    .ovf(ras_ovf),
    .unf(ras_unf)
  );
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the MIPS fetch stage.
- Replaces the fixed load-address PC with on-chip next-PC selection: sequential, PC-relative branch, absolute jump and register jump.
- Adds stall hold, an exception redirect and a return-address stack (RAS) for call/return.
- Feeds instruction memory address and the pc_inc value used by link writes.

Parameters:
- ADDR_W, 32, PC width in bits (minimum 8).
- INC, 4, sequential increment in bytes (power of two).
- RESET_VEC, 32'h0000_0000, PC value after reset.
- EXC_VEC, 32'h0000_0080, exception handler address.
- OFF_W, 16, branch offset width in words (signed).
- RAS_DEPTH, 4, return-address stack entries (power of two, minimum 2).

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst_n, in, 1, synchronous active-low reset.
- stall, in, 1, hold PC and RAS this cycle.
- exc, in, 1, redirect to EXC_VEC; overrides everything, including stall.
- br_taken, in, 1, take a PC-relative branch.
- br_off, in, OFF_W, signed word offset.
- jump, in, 1, absolute jump.
- jump_tgt, in, ADDR_W, absolute target.
- jr, in, 1, register jump.
- jr_tgt, in, ADDR_W, register target.
- call, in, 1, push return address; qualifies jump or jr.
- ret, in, 1, pop RAS and use it as the target.
- pc, out, ADDR_W, current PC (registered).
- pc_inc, out, ADDR_W, pc+INC (combinational from pc).
- ras_count, out, clog2(RAS_DEPTH)+1, valid RAS entries.
- ras_ovf, out, 1, one-cycle pulse: push while full.
- ras_unf, out, 1, one-cycle pulse: pop while empty.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - pc=RESET_VEC, ras_count=0, ras_ovf=0, ras_unf=0, RAS write pointer=0.
  - Entry contents are don't-care.
  - Reset dominates every other input, including exc.
- Next-PC priority, evaluated each cycle when not in reset:
  1. exc: pc<=EXC_VEC. RAS unchanged, no flags.
  2. stall: pc held. RAS held. All other controls ignored, no flags.
  3. ret: pc<=RAS top, or jr_tgt when ras_count==0 (then ras_unf=1).
  4. jr: pc<=jr_tgt.
  5. jump: pc<=jump_tgt.
  6. br_taken: pc<=pc_inc + (sign_extend(br_off)<<2), modulo 2^ADDR_W.
  7. Otherwise: pc<=pc_inc.
- Target alignment: low log2(INC) bits of every computed target are forced to 0.
- Latency: the new pc is visible one cycle after the control is sampled. There is no delay slot.
- Wrap-around: pc_inc and branch targets wrap modulo 2^ADDR_W, with no error.
- RAS is a circular buffer of RAS_DEPTH entries.
- push (call=1, and jump or jr selected):
  - Write pc_inc at the write pointer, then increment the pointer.
  - ras_count saturates at RAS_DEPTH.
  - When full, the oldest entry is overwritten and ras_ovf=1 for one cycle.
- call without jump/jr is ignored.
- pop (ret selected, count>0): decrement the pointer and ras_count. The target is the entry at pointer-1.
- call and ret together, count>0: the target is the old top; that slot is overwritten with pc_inc; ras_count is unchanged.
- call and ret together, count==0: target is jr_tgt; ras_unf=1; pc_inc is pushed, so count becomes 1.
- ret also wins over a simultaneous jr/jump/br_taken.
- Flags are registered pulses. They clear the next cycle unless the condition repeats.
- An exc in the same cycle as call/ret suppresses the RAS update.

Decomposition:
- Shared package pc_pkg holds:
  - the next-PC select enum: SEL_EXC, SEL_HOLD, SEL_RET, SEL_JR, SEL_JMP, SEL_BR, SEL_SEQ;
  - default vector constants RESET_VEC_DEF and EXC_VEC_DEF;
  - the alignment helper function.
- One sub-module, ras_stack: circular buffer, pointer, count and flags, with push/pop/top ports.
- The top level holds the priority mux and the pc register.

Test Plan:
- Reset then 5 free cycles, defaults: pc 0,4,8,12,16,20; pc_inc always equals pc+4.
- At pc=0x40, br_taken=1, br_off=-4 (0xFFFC): next pc=0x34. With br_off=0x0003: next pc=0x50.
- At pc=0x100, jump=1, call=1, jump_tgt=0x2000: pc=0x2000, ras_count=1. Two cycles later, ret=1: pc=0x104, ras_count=0.
- RAS_DEPTH=4, 5 calls from pcs 0x10,0x20,0x30,0x40,0x50: ras_ovf pulses on the 5th; four rets return 0x54,0x44,0x34,0x24; a 5th ret with jr_tgt=0x900 gives pc=0x900 and ras_unf=1.
- Stall held 3 cycles at pc=0x80 with jump=1: pc stays 0x80. exc asserted during the stall: pc=0x80 (EXC_VEC), RAS unchanged.
- pc=0xFFFF_FFFC sequential: next pc=0x0. rst_n=0 mid-call (ras_count=2): next cycle pc=RESET_VEC, ras_count=0, flags 0.
